// File: rtl/icache_sa_if.sv
// Fetch-side and MemCtrl-side signals of the set-associative I-cache.
// The cache takes the slave view; IF/MemCtrl (or a bench) take the master view.
interface icache_sa_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic [ADDR_W-1:0] pc;
  logic              jp_wrong;
  logic              inv_all;
  logic              busy;
  logic              ins_valid;
  logic [31:0]       ins;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_data;

  modport slave (
    input  req, pc, jp_wrong, inv_all, mem_ack, mem_data,
    output busy, ins_valid, ins, mem_req, mem_addr
  );

  modport master (
    output req, pc, jp_wrong, inv_all, mem_ack, mem_data,
    input  busy, ins_valid, ins, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache with multi-word lines: one-cycle hits,
// word-by-word line refill on a miss, squash and whole-cache invalidate.
module icache_sa #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  icache_sa_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_t;
  state_t r_state, w_state_next;

  logic [31:0]               r_data [WAYS][SETS*LINE_WORDS];
  logic [TAG_W-1:0]          r_tag  [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0] r_valid;
  logic [WAY_W-1:0]          r_rr   [SETS];

  logic [TAG_W-1:0] r_mtag;
  logic [IDX_W-1:0] r_midx;
  logic [OFF_W-1:0] r_moff;
  logic [OFF_W-1:0] r_k;
  logic [WAY_W-1:0] r_vway;
  logic             r_squash;
  logic             r_ins_valid;
  logic [31:0]      r_ins;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [WAYS-1:0]  w_way_hit;
  logic [31:0]      w_way_word [WAYS];
  logic [31:0]      w_hit_word;
  logic             w_hit;
  logic [WAY_W-1:0] w_victim;
  logic             w_fire;
  logic             w_last;

  assign w_off = bus.pc[OFF_W+1:2];
  assign w_idx = bus.pc[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag = bus.pc[ADDR_W-1:ADDR_W-TAG_W];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign w_way_hit[gi]  = r_valid[gi][w_idx] && (r_tag[gi][w_idx] == w_tag);
      assign w_way_word[gi] = w_way_hit[gi] ? r_data[gi][{w_idx, w_off}] : 32'h0;
    end
  endgenerate

  assign w_hit = |w_way_hit;

  always_comb begin
    w_hit_word = '0;
    for (int i = 0; i < WAYS; i++) w_hit_word = w_hit_word | w_way_word[i];
  end

  // Prefer the lowest-numbered empty way; only fall back to round-robin when the set is full.
  always_comb begin
    w_victim = r_rr[w_idx];
    for (int i = WAYS - 1; i >= 0; i--)
      if (!r_valid[i][w_idx]) w_victim = WAY_W'(i);
  end

  assign w_fire = rdy && bus.mem_ack && (r_state == S_REFILL);
  assign w_last = w_fire && (r_k == {OFF_W{1'b1}});

  always_comb begin
    w_state_next = r_state;
    if (rdy) begin
      case (r_state)
        S_IDLE:   if (bus.req && !w_hit) w_state_next = S_REFILL;
        S_REFILL: if (w_last) w_state_next = S_RESP;
        S_RESP:   w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
      r_mtag      <= '0;
      r_midx      <= '0;
      r_moff      <= '0;
      r_k         <= '0;
      r_vway      <= '0;
      r_squash    <= 1'b0;
      r_ins_valid <= 1'b0;
      r_ins       <= '0;
    end else if (rdy) begin
      r_ins_valid <= 1'b0;
      if (bus.inv_all) r_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            if (w_hit) begin
              r_ins_valid <= !bus.jp_wrong;
              r_ins       <= w_hit_word;
            end else begin
              r_mtag   <= w_tag;
              r_midx   <= w_idx;
              r_moff   <= w_off;
              r_vway   <= w_victim;
              r_k      <= '0;
              r_squash <= bus.jp_wrong;
            end
          end
        end
        S_REFILL: begin
          if (bus.jp_wrong) r_squash <= 1'b1;
          if (w_fire) begin
            r_k <= r_k + 1'b1;
            if (r_k == r_moff) r_ins <= bus.mem_data;
            // Installing after a same-cycle inv_all clear keeps the freshly filled line.
            if (w_last) begin
              r_valid[r_vway][r_midx] <= 1'b1;
              r_rr[r_midx]            <= (WAYS == 1) ? '0 : r_rr[r_midx] + 1'b1;
              r_ins_valid             <= !(r_squash || bus.jp_wrong);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_data[r_vway][{r_midx, r_k}] <= bus.mem_data;
      if (w_last) r_tag[r_vway][r_midx] <= r_mtag;
    end
  end

  assign bus.busy      = (r_state == S_REFILL);
  assign bus.mem_req   = (r_state == S_REFILL);
  assign bus.mem_addr  = bus.mem_req ? {r_mtag, r_midx, r_k, 2'b00} : '0;
  assign bus.ins_valid = r_ins_valid && !((r_state == S_RESP) && bus.jp_wrong);
  assign bus.ins       = r_ins;
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: MemCtrl model acks each word two cycles after
// mem_req and returns addr ^ 0xDEAD0000, so expected words are easy to hand-compute.
module tb_icache_sa;
  logic clk;
  logic rst_n;
  logic rdy;

  icache_sa_if #(.ADDR_W(32)) bus ();

  icache_sa #(.WAYS(2), .SETS(64), .LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_now = 0;
  int last_ack_cyc = 0;
  logic [31:0] addr_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // MemCtrl model: ack on the second falling edge after mem_req is seen.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req && rdy && rst_n) begin
        if (wait_cnt == 1) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = bus.mem_addr ^ 32'hDEAD0000;
          addr_log.push_back(bus.mem_addr);
          last_ack_cyc = cyc_now;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp, input bit exp_hit);
    int n0;
    int g;
    int got_acks;
    logic [31:0] base;
    n0 = addr_log.size();
    base = a & ~32'hF;
    bus.req = 1'b1;
    bus.pc  = a;
    tick();
    if (exp_hit) begin
      chk({tag, "_hit_valid"}, {31'b0, bus.ins_valid}, 32'd1);
      chk({tag, "_hit_ins"}, bus.ins, exp);
      chk({tag, "_hit_nobusy"}, {31'b0, bus.busy}, 32'd0);
      bus.req = 1'b0;
    end else begin
      chk({tag, "_miss_busy"}, {31'b0, bus.busy}, 32'd1);
      g = 0;
      while (!bus.ins_valid && g < 200) begin
        tick();
        g++;
      end
      chk({tag, "_miss_done"}, {31'b0, bus.ins_valid}, 32'd1);
      chk({tag, "_miss_ins"}, bus.ins, exp);
      chk({tag, "_resp_lat"}, cyc_now - last_ack_cyc, 32'd1);
      got_acks = addr_log.size() - n0;
      chk({tag, "_acks"}, got_acks, 32'd4);
      for (int k = 0; k < 4 && k < got_acks; k++)
        chk($sformatf("%s_addr%0d", tag, k), addr_log[n0 + k], base + 32'(4 * k));
      bus.req = 1'b0;
    end
    $display("fetch %s pc=%h hit=%0d ins=%h", tag, a, exp_hit, bus.ins);
  endtask

  initial begin
    int n0;
    int g;
    bit seen;
    rst_n = 1'b0;
    rdy = 1'b1;
    bus.req = 1'b0;
    bus.pc = '0;
    bus.jp_wrong = 1'b0;
    bus.inv_all = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_ins_valid", {31'b0, bus.ins_valid}, 32'd0);
    chk("rst_ins", bus.ins, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    fetch("t1_cold", 32'h100, 32'hDEAD0100, 1'b0);
    tick();
    fetch("t2_hit", 32'h108, 32'hDEAD0108, 1'b1);
    tick();

    fetch("t3_fill1100", 32'h1100, 32'hDEAD1100, 1'b0);
    tick();
    fetch("t3_hit100", 32'h100, 32'hDEAD0100, 1'b1);
    fetch("t3_hit110c", 32'h110C, 32'hDEAD110C, 1'b1);
    fetch("t3_fill2100", 32'h2100, 32'hDEAD2100, 1'b0);
    tick();
    fetch("t3_hit1104", 32'h1104, 32'hDEAD1104, 1'b1);
    fetch("t3_evict100", 32'h100, 32'hDEAD0100, 1'b0);
    tick();

    // Squash in the middle of a refill.
    n0 = addr_log.size();
    bus.req = 1'b1;
    bus.pc = 32'h200;
    tick();
    chk("t4_busy", {31'b0, bus.busy}, 32'd1);
    g = 0;
    while (addr_log.size() < n0 + 1 && g < 100) begin
      tick();
      g++;
    end
    bus.jp_wrong = 1'b1;
    tick();
    bus.jp_wrong = 1'b0;
    seen = 1'b0;
    g = 0;
    while (bus.busy && g < 100) begin
      tick();
      g++;
      if (bus.ins_valid) seen = 1'b1;
    end
    chk("t4_refill_done", {31'b0, bus.busy}, 32'd0);
    chk("t4_no_ins", {31'b0, seen}, 32'd0);
    chk("t4_acks", addr_log.size() - n0, 32'd4);
    bus.req = 1'b0;
    $display("squash pc=00000200 acks=%0d", addr_log.size() - n0);
    tick();
    fetch("t4_hit200", 32'h200, 32'hDEAD0200, 1'b1);
    tick();

    bus.inv_all = 1'b1;
    tick();
    bus.inv_all = 1'b0;
    $display("inv_all pulse");
    fetch("t5_inv108", 32'h108, 32'hDEAD0108, 1'b0);
    tick();
    fetch("t5_inv20c", 32'h20C, 32'hDEAD020C, 1'b0);
    tick();

    bus.req = 1'b1;
    bus.pc = 32'h104;
    bus.jp_wrong = 1'b1;
    tick();
    chk("jp_hit_killed", {31'b0, bus.ins_valid}, 32'd0);
    chk("jp_hit_nomiss", {31'b0, bus.busy}, 32'd0);
    bus.req = 1'b0;
    bus.jp_wrong = 1'b0;
    $display("jp_wrong hit pc=00000104");
    tick();

    // Freeze mid-refill, then asynchronous reset mid-refill.
    n0 = addr_log.size();
    bus.req = 1'b1;
    bus.pc = 32'h300;
    tick();
    g = 0;
    while (addr_log.size() < n0 + 1 && g < 100) begin
      tick();
      g++;
    end
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_frz_busy", {31'b0, bus.busy}, 32'd1);
    chk("t6_frz_mem_req", {31'b0, bus.mem_req}, 32'd1);
    chk("t6_frz_addr", bus.mem_addr, 32'h304);
    chk("t6_frz_acks", addr_log.size() - n0, 32'd1);
    rdy = 1'b1;
    tick();
    tick();
    bus.req = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("t6_arst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("t6_arst_addr", bus.mem_addr, 32'd0);
    $display("async reset mid-refill pc=00000300");
    tick();
    rst_n = 1'b1;
    tick();
    fetch("t6_after_rst", 32'h100, 32'hDEAD0100, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
